hazard_unit: RTL and testbench

Pipeline hazard responder for the 5-stage MIPS core. It consumes the per-stage control bits the controller pipelines (RegWrite/MemToReg in E/M/W, BranchD, JumpD, PCSrcD) and the register numbers in D/E/M/W. It returns the stall, flush and forwarding controls to the datapath and to the controller's FlushE input. It also owns a data-memory wait FSM with a timeout watchdog that freezes the pipe while the data memory is not ready.

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/hazard_fwd.sv | 33 +++
 rtl/hazard_unit.sv | 195 +++++++++++++++++++
 tb/tb_hazard_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the MIPS pipeline hazard unit.
// Holds the memory-wait FSM encoding, forward selects and the register match helper.
package hazard_unit_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // r0 is hard-wired to zero, so a write to it never creates a dependency.
   function automatic logic reg_hit(input logic       we,
                                    input logic [4:0] wr,
                                    input logic [4:0] src);
      return we && (wr != 5'd0) && (wr == src);
   endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Per-operand forwarding select: E-stage ALU operand mux and D-stage comparator bypass.
module hazard_fwd
   import hazard_unit_pkg::*;
(
   input  logic [4:0] i_src_e,
   input  logic [4:0] i_src_d,
   input  logic       i_reg_write_m,
   input  logic [4:0] i_write_reg_m,
   input  logic       i_reg_write_w,
   input  logic [4:0] i_write_reg_w,
   output logic [1:0] o_fwd_e,
   output logic       o_fwd_d
);

   logic w_hit_m_e;
   logic w_hit_w_e;

   assign w_hit_m_e = reg_hit(i_reg_write_m, i_write_reg_m, i_src_e);
   assign w_hit_w_e = reg_hit(i_reg_write_w, i_write_reg_w, i_src_e);

   // The younger M result shadows an older W write to the same register.
   always_comb begin
      o_fwd_e = FWD_RF;
      if (w_hit_m_e) begin
         o_fwd_e = FWD_M;
      end else if (w_hit_w_e) begin
         o_fwd_e = FWD_W;
      end
   end

   assign o_fwd_d = reg_hit(i_reg_write_m, i_write_reg_m, i_src_d);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage MIPS core with a data-memory wait watchdog.
// Optional HAZARD_PERF_EN adds saturating 32-bit stall-cause counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int TW          = 8
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemToRegE,
   input  logic       MemToRegM,
   input  logic       BranchD,
   input  logic       JumpD,
   input  logic       PCSrcD,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MemErr
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] LoadStallCnt,
   output logic [31:0] BranchStallCnt,
   output logic [31:0] MemStallCnt
`endif
);

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

   hz_state_e     r_state;
   hz_state_e     w_state_nxt;
   logic [TW-1:0] r_wait_cnt;
   logic [TW-1:0] w_wait_cnt_nxt;
   logic          r_mem_err;
   logic          w_err_set;

   logic w_lwstall;
   logic w_brstall;
   logic w_memstall;

   hazard_fwd u_fwd_a (
      .i_src_e       (RsE),
      .i_src_d       (RsD),
      .i_reg_write_m (RegWriteM),
      .i_write_reg_m (WriteRegM),
      .i_reg_write_w (RegWriteW),
      .i_write_reg_w (WriteRegW),
      .o_fwd_e       (ForwardAE),
      .o_fwd_d       (ForwardAD)
   );

   hazard_fwd u_fwd_b (
      .i_src_e       (RtE),
      .i_src_d       (RtD),
      .i_reg_write_m (RegWriteM),
      .i_write_reg_m (WriteRegM),
      .i_reg_write_w (RegWriteW),
      .i_write_reg_w (WriteRegW),
      .o_fwd_e       (ForwardBE),
      .o_fwd_d       (ForwardBD)
   );

   assign w_lwstall = MemToRegE &
                      (reg_hit(RegWriteE, WriteRegE, RsD) |
                       reg_hit(RegWriteE, WriteRegE, RtD));

   assign w_brstall = BranchD &
                      (reg_hit(RegWriteE, WriteRegE, RsD) |
                       reg_hit(RegWriteE, WriteRegE, RtD) |
                       reg_hit(MemToRegM, WriteRegM, RsD) |
                       reg_hit(MemToRegM, WriteRegM, RtD));

   // Suppressed after a timeout so the pipe drains on whatever the bus holds.
   assign w_memstall = MemReqM & ~MemReadyM & ~r_mem_err;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_err_set) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_err_set      = 1'b0;
      case (r_state)
         RUN: begin
            w_wait_cnt_nxt = '0;
            if (MemReqM && !MemReadyM) begin
               w_state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (MemReadyM) begin
               w_state_nxt    = RUN;
               w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt == TIMEOUT_LAST) begin
               w_state_nxt    = RUN;
               w_wait_cnt_nxt = '0;
               w_err_set      = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (Reset) begin
         if (w_memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (w_lwstall || w_brstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else if (PCSrcD || JumpD) begin
            FlushD = 1'b1;
         end
      end
   end

   assign MemErr = r_mem_err;

`ifdef HAZARD_PERF_EN
   logic w_win_mem;
   logic w_win_load;
   logic w_win_branch;

   assign w_win_mem    = w_memstall;
   assign w_win_load   = ~w_memstall & w_lwstall;
   assign w_win_branch = ~w_memstall & w_brstall;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         LoadStallCnt   <= '0;
         BranchStallCnt <= '0;
         MemStallCnt    <= '0;
      end else begin
         if (w_win_load && (LoadStallCnt != '1)) begin
            LoadStallCnt <= LoadStallCnt + 32'd1;
         end
         if (w_win_branch && (BranchStallCnt != '1)) begin
            BranchStallCnt <= BranchStallCnt + 32'd1;
         end
         if (w_win_mem && (MemStallCnt != '1)) begin
            MemStallCnt <= MemStallCnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit, built with a short memory timeout.
module tb_hazard_unit;

   logic       CLK;
   logic       Reset;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemToRegE, MemToRegM;
   logic       BranchD, JumpD, PCSrcD;
   logic       MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       MemErr;
`ifdef HAZARD_PERF_EN
   logic [31:0] LoadStallCnt, BranchStallCnt, MemStallCnt;
`endif

   typedef struct {
      string       tag;
      logic [13:0] v;
   } exp_t;

   exp_t q[$];
   int   vectors;
   int   miscompares;

   hazard_unit #(
      .MEM_TIMEOUT (4),
      .TW          (8)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .RsD       (RsD),
      .RtD       (RtD),
      .RsE       (RsE),
      .RtE       (RtE),
      .WriteRegE (WriteRegE),
      .WriteRegM (WriteRegM),
      .WriteRegW (WriteRegW),
      .RegWriteE (RegWriteE),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .MemToRegE (MemToRegE),
      .MemToRegM (MemToRegM),
      .BranchD   (BranchD),
      .JumpD     (JumpD),
      .PCSrcD    (PCSrcD),
      .MemReqM   (MemReqM),
      .MemReadyM (MemReadyM),
      .StallF    (StallF),
      .StallD    (StallD),
      .StallE    (StallE),
      .StallM    (StallM),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .FlushW    (FlushW),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .ForwardAD (ForwardAD),
      .ForwardBD (ForwardBD),
      .MemErr    (MemErr)
`ifdef HAZARD_PERF_EN
      ,
      .LoadStallCnt   (LoadStallCnt),
      .BranchStallCnt (BranchStallCnt),
      .MemStallCnt    (MemStallCnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected vector: {StallF,D,E,M}, {FlushD,E,W}, ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr
   function automatic logic [13:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic fad, input logic fbd, input logic err);
      return {st, fl, fae, fbe, fad, fbd, err};
   endfunction

   task automatic clear_inputs();
      RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
      WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemToRegE = 1'b0; MemToRegM = 1'b0;
      BranchD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic load_use_inputs();
      MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
   endtask

   // Inputs are already driven; sample on the falling edge, then advance past the next rising edge.
   task automatic step(input string tag, input logic [13:0] e);
      exp_t        t;
      logic [13:0] obs;
      q.push_back('{tag: tag, v: e});
      @(negedge CLK);
      t   = q.pop_front();
      obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr};
      vectors++;
      assert (obs === t.v) else begin
         miscompares++;
         $error("FAIL %s: observed %b required %b", t.tag, obs, t.v);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b0;
      clear_inputs();

      MemReqM = 1'b1; load_use_inputs(); BranchD = 1'b1; PCSrcD = 1'b1;
      step("reset_forces_zero", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
      Reset = 1'b1;

      clear_inputs();
      step("idle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      RegWriteM = 1'b1; WriteRegM = 5'd5; RsE = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; RtE = 5'd7;
      step("fwd_m_over_w", mk(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0, 0));

      clear_inputs();
      RegWriteW = 1'b1; WriteRegW = 5'd9; RsE = 5'd3; RtE = 5'd9;
      step("fwd_w_b", mk(4'b0000, 3'b000, 2'b00, 2'b01, 0, 0, 0));

      clear_inputs();
      RegWriteM = 1'b1; RegWriteW = 1'b1;
      step("r0_no_match", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      RegWriteM = 1'b1; WriteRegM = 5'd12; RsD = 5'd12; RtD = 5'd13; RtE = 5'd12;
      step("fwd_d_and_be", mk(4'b0000, 3'b000, 2'b00, 2'b10, 1, 0, 0));

      clear_inputs();
      load_use_inputs();
      step("lwstall", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      step("lwstall_one_cycle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3; PCSrcD = 1'b1;
      step("brstall_e", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd3;
      step("branch_taken_flush", mk(4'b0000, 3'b100, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      BranchD = 1'b1; MemToRegM = 1'b1; WriteRegM = 5'd4; RtD = 5'd4;
      step("brstall_m_load", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      JumpD = 1'b1;
      step("jump_flush", mk(4'b0000, 3'b100, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      MemToRegE = 1'b1; RegWriteE = 1'b1; BranchD = 1'b1;
      step("r0_no_stall", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      MemReqM = 1'b1; load_use_inputs();
      step("memstall_over_lw", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      clear_inputs();
      MemReqM = 1'b1;
      step("memwait_1", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      step("memwait_2", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      MemReadyM = 1'b1;
      step("mem_ready_drops", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
      clear_inputs();
      step("back_in_run", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
      MemReqM = 1'b1; MemReadyM = 1'b1;
      step("ready_same_cycle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));

      clear_inputs();
      MemReqM = 1'b1; JumpD = 1'b1;
      step("memstall_over_jump", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      JumpD = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("timeout_wait_%0d", i), mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      end
      step("timeout_err", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1));
      step("err_no_stall", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1));
      clear_inputs();
      load_use_inputs();
      step("err_sticky_lw", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 1));

      Reset = 1'b0;
      clear_inputs();
      step("reset_clears_err", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
      Reset = 1'b1;

      MemReqM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step($sformatf("prewait_%0d", i), mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      end
      Reset = 1'b0;
      step("reset_mid_wait", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
      Reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step($sformatf("rewait_%0d", i), mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0));
      end
      step("rewait_err", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
